// File: rtl/mp_adder_sched_if.sv
// mp_adder_sched_if: requester beat streams (req_*) in and the tagged result stream (res_*) out; master is the requester/sink side, slave is the scheduler
interface mp_adder_sched_if #(
  parameter int W = 32,
  parameter int NREQ = 2
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0] req_sub;
  logic [NREQ-1:0] req_last;
  logic res_valid;
  logic res_ready;
  logic [W-1:0] res_sum;
  logic [IW-1:0] res_id;
  logic res_last;
  logic res_carry;
  logic res_err;
  modport master (
    output req_valid, req_a, req_b, req_sub, req_last, res_ready,
    input req_ready, res_valid, res_sum, res_id, res_last, res_carry, res_err
  );
  modport slave (
    input req_valid, req_a, req_b, req_sub, req_last, res_ready,
    output req_ready, res_valid, res_sum, res_id, res_last, res_carry, res_err
  );
endinterface

// File: rtl/mp_adder_sched.sv
// mp_adder_sched: round-robin scheduler sharing one multi-word carry-chained add/sub datapath; ports clk, rst_n (async active-low), bus (slave: req_* in, registered res_* out)
module mp_adder_sched #(
  parameter int W = 32,
  parameter int NREQ = 2,
  parameter int MAX_WORDS = 8
) (
  input logic clk,
  input logic rst_n,
  mp_adder_sched_if.slave bus
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = MAX_WORDS > 1 ? $clog2(MAX_WORDS) : 1;
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] g, g_nxt, g_inc, rr_ptr, pick;
  logic [CW-1:0] cnt;
  logic carry, sub_l, found, acc_ok, accept, first, sub_eff, cin, term, force_end;
  logic [W-1:0] a, b;
  logic [W:0] sum;
  always_comb begin
    int j;
    j = 0;
    pick = rr_ptr;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      j = j >= NREQ ? j - NREQ : j;
      if (bus.req_valid[j]) begin
        pick = IW'(j);
        found = 1'b1;
      end
    end
  end
  assign acc_ok = ~bus.res_valid | bus.res_ready;
  assign accept = state == LOCK && bus.req_valid[g] && acc_ok;
  assign first = cnt == '0;
  assign sub_eff = first ? bus.req_sub[g] : sub_l;
  assign cin = first ? bus.req_sub[g] : carry;
  assign a = bus.req_a[g*W +: W];
  assign b = bus.req_b[g*W +: W];
  assign sum = {1'b0, a} + {1'b0, sub_eff ? ~b : b} + {{W{1'b0}}, cin};
  assign force_end = ~bus.req_last[g] & (cnt == CW'(MAX_WORDS - 1));
  assign term = bus.req_last[g] | force_end;
  assign g_inc = g == IW'(NREQ - 1) ? '0 : g + 1'b1;
  assign bus.req_ready = state == LOCK && acc_ok ? NREQ'(1) << g : '0;
  always_comb begin
    state_nxt = state;
    g_nxt = g;
    if (state == IDLE && found) begin
      state_nxt = LOCK;
      g_nxt = pick;
    end else if (accept && term) begin
      state_nxt = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      g <= '0;
      rr_ptr <= '0;
      cnt <= '0;
      carry <= 1'b0;
      sub_l <= 1'b0;
    end else begin
      state <= state_nxt;
      g <= g_nxt;
      if (accept) begin
        cnt <= term ? '0 : cnt + 1'b1;
        carry <= term ? 1'b0 : sum[W];
        sub_l <= sub_eff;
        if (term) rr_ptr <= g_inc;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.res_valid <= 1'b0;
      bus.res_sum <= '0;
      bus.res_id <= '0;
      bus.res_last <= 1'b0;
      bus.res_carry <= 1'b0;
      bus.res_err <= 1'b0;
    end else if (accept) begin
      bus.res_valid <= 1'b1;
      bus.res_sum <= sum[W-1:0];
      bus.res_id <= g;
      bus.res_last <= term;
      bus.res_carry <= sum[W];
      bus.res_err <= force_end;
    end else if (bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mp_adder_sched.sv
// tb_mp_adder_sched: directed and randomized checks of mp_adder_sched against a wide-integer reference model
module tb_mp_adder_sched;
  localparam int W = 32;
  localparam int N = 2;
  localparam int MW = 4;
  typedef struct {logic [W-1:0] a, b; logic sub, last;} beat_t;
  typedef struct {logic [W-1:0] sum; logic carry, last, err;} exp_t;
  logic clk, rst_n;
  mp_adder_sched_if #(.W(W), .NREQ(N)) bus ();
  mp_adder_sched #(.W(W), .NREQ(N), .MAX_WORDS(MW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int nvec = 0, nerr = 0, rdy_mode = 0;
  beat_t sq[N][$];
  beat_t ck[N][$];
  exp_t eq[N][$];
  int log_q[$];
  logic [N-1:0] took = '0;
  logic stall = 1'b0;
  logic [W+3:0] held;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push_beat(input int i, input beat_t bt);
    logic [MW*W:0] aa, bb, s;
    exp_t e;
    int n;
    sq[i].push_back(bt);
    ck[i].push_back(bt);
    if (bt.last || ck[i].size() == MW) begin
      n = ck[i].size();
      aa = '0;
      bb = '0;
      for (int k = 0; k < n; k++) begin
        aa[k*W +: W] = ck[i][k].a;
        bb[k*W +: W] = ck[i][0].sub ? ~ck[i][k].b : ck[i][k].b;
        s = aa + bb + {{(MW*W){1'b0}}, ck[i][0].sub};
        e.sum = s[k*W +: W];
        e.carry = s[(k+1)*W];
        e.last = k == n - 1;
        e.err = k == n - 1 && !ck[i][k].last;
        eq[i].push_back(e);
      end
      ck[i].delete();
    end
  endtask
  task automatic cycle();
    int id;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (took[i]) void'(sq[i].pop_front());
      bus.req_valid[i] = sq[i].size() > 0 && (rdy_mode != 1 || $urandom_range(0, 3) != 0);
      if (sq[i].size() > 0) begin
        bus.req_a[i*W +: W] = sq[i][0].a;
        bus.req_b[i*W +: W] = sq[i][0].b;
        bus.req_sub[i] = sq[i][0].sub;
        bus.req_last[i] = sq[i][0].last;
      end
    end
    bus.res_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 2 ? 1'b0 : $urandom_range(0, 3) != 0;
    #1;
    chk("ready_onehot", 64'($onehot0(bus.req_ready)), 1);
    if (stall) chk("held", {bus.res_sum, bus.res_carry, bus.res_last, bus.res_err, bus.res_id}, held);
    stall = bus.res_valid && !bus.res_ready;
    if (stall) begin
      held = {bus.res_sum, bus.res_carry, bus.res_last, bus.res_err, bus.res_id};
      chk("stall_ready", bus.req_ready, 0);
    end
    if (bus.res_valid && bus.res_ready) begin
      id = int'(bus.res_id);
      log_q.push_back(id);
      chk("beat_expected", 64'(eq[id].size() != 0), 1);
      if (eq[id].size() != 0) begin
        chk("beat", {bus.res_sum, bus.res_carry, bus.res_last, bus.res_err},
            {eq[id][0].sum, eq[id][0].carry, eq[id][0].last, eq[id][0].err});
        void'(eq[id].pop_front());
      end
    end
    took = bus.req_valid & bus.req_ready;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sq[0].size() + sq[1].size() + eq[0].size() + eq[1].size() != 0 && n < 3000) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 64'(n < 3000), 1);
  endtask
  task automatic flush();
    for (int i = 0; i < N; i++) begin
      sq[i].delete();
      ck[i].delete();
      eq[i].delete();
    end
    took = '0;
    stall = 1'b0;
    bus.req_valid = '0;
    log_q.delete();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flush();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  function automatic beat_t rnd_beat(input logic sub, input logic last);
    beat_t bt;
    bt.a = $urandom_range(0, 3) == 0 ? '1 : $urandom;
    bt.b = $urandom_range(0, 3) == 0 ? '0 : $urandom;
    bt.sub = sub;
    bt.last = last;
    return bt;
  endfunction
  initial begin
    int len, rq;
    logic sb;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_sub = '0;
    bus.req_last = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {bus.res_valid, bus.res_sum, bus.res_id, bus.res_last, bus.res_carry, bus.res_err}, 0);
    chk("rst_ready", bus.req_ready, 0);
    rst_n = 1'b1;
    push_beat(0, '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0});
    push_beat(0, '{32'h00000000, 32'h00000000, 1'b0, 1'b1});
    drain();
    push_beat(1, '{32'h00000000, 32'h00000001, 1'b1, 1'b1});
    drain();
    do_reset();
    push_beat(0, rnd_beat(1'b0, 1'b1));
    push_beat(0, rnd_beat(1'b1, 1'b1));
    push_beat(1, rnd_beat(1'b0, 1'b1));
    drain();
    chk("rr_order", {32'(log_q.size()), 8'(log_q[0]), 8'(log_q[1]), 8'(log_q[2])}, {32'd3, 8'd0, 8'd1, 8'd0});
    for (int k = 0; k < 4; k++) push_beat(0, rnd_beat($urandom_range(0, 1) == 1, k == 3));
    cycle();
    cycle();
    cycle();
    rdy_mode = 2;
    repeat (5) cycle();
    chk("stall_seen", 64'(stall), 1);
    rdy_mode = 0;
    drain();
    for (int k = 0; k < 6; k++) push_beat(0, rnd_beat(k == 0 || k == 4 ? 1'b1 : $urandom_range(0, 1) == 1, k == 5));
    drain();
    do_reset();
    for (int k = 0; k < 3; k++) push_beat(0, rnd_beat(1'b0, k == 2));
    cycle();
    cycle();
    cycle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {bus.res_valid, bus.res_sum, bus.res_id, bus.res_last, bus.res_carry, bus.res_err}, 0);
    chk("async_rst_ready", bus.req_ready, 0);
    flush();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_beat(1, rnd_beat(1'b1, 1'b1));
    drain();
    chk("rst_arb", log_q.size() > 0 ? 64'(log_q[0]) : '1, 1);
    rdy_mode = 1;
    for (int t = 0; t < 40; t++) begin
      rq = $urandom_range(0, N - 1);
      len = $urandom_range(1, MW);
      sb = $urandom_range(0, 1) == 1;
      for (int k = 0; k < len; k++) push_beat(rq, rnd_beat(k == 0 ? sb : $urandom_range(0, 1) == 1, k == len - 1));
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
